// File: rtl/cache_fill_fsm.sv
// Cache line fill controller: requests a WORDS-word line from pipelined memory and streams returns into the data array.
// Optional critical-word-first ordering is enabled by defining CRITICAL_WORD_FIRST_EN.
module cache_fill_fsm #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned WORDS  = 8,
    parameter int unsigned OFFS_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              miss_way,
    input  logic              memory_data_valid,
    input  logic [15:0]       memory_data,
    output logic              fsm_busy,
    output logic              memory_req,
    output logic [ADDR_W-1:0] memory_address,
    output logic              write_data_array,
    output logic              write_tag_array,
    output logic              fill_way,
    output logic [WORDS-1:0]  word_enable,
    output logic [15:0]       data_out
);

    localparam int unsigned CNT_W = $clog2(WORDS + 1);
    localparam int unsigned IDX_W = $clog2(WORDS);
    localparam logic [ADDR_W-1:0] OFFS_MASK = ADDR_W'((1 << OFFS_W) - 1);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  req_cnt;
    logic [IDX_W-1:0]  rcv_cnt;
    logic              way;
    logic              req_pending;
    logic              last_word;
    logic [IDX_W-1:0]  req_slot;
    logic [IDX_W-1:0]  req_idx;
    logic [IDX_W-1:0]  wr_idx;

    assign req_pending = (req_cnt < CNT_W'(WORDS));
    assign last_word   = (rcv_cnt == IDX_W'(WORDS - 1));
    // Once every request is out the address holds on the last word issued.
    assign req_slot    = req_pending ? req_cnt[IDX_W-1:0] : IDX_W'(WORDS - 1);

`ifdef CRITICAL_WORD_FIRST_EN
    logic [IDX_W-1:0] crit;

    // Index arithmetic wraps naturally at IDX_W bits, giving mod WORDS.
    assign req_idx = crit + req_slot;
    assign wr_idx  = crit + rcv_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crit <= '0;
        end else if (state == IDLE && miss_detected) begin
            crit <= miss_address[OFFS_W-1:1];
        end
    end
`else
    assign req_idx = req_slot;
    assign wr_idx  = rcv_cnt;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (miss_detected) state_nxt = FILL;
            FILL:    if (memory_data_valid && last_word) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Fill bookkeeping registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base    <= '0;
            req_cnt <= '0;
            rcv_cnt <= '0;
            way     <= 1'b0;
        end else if (state == IDLE) begin
            if (miss_detected) begin
                base    <= miss_address & ~OFFS_MASK;
                way     <= miss_way;
                req_cnt <= '0;
                rcv_cnt <= '0;
            end
        end else begin
            if (req_pending) req_cnt <= req_cnt + CNT_W'(1);
            if (memory_data_valid) rcv_cnt <= rcv_cnt + IDX_W'(1);
        end
    end

    // Outputs: same-cycle response to memory returns, gated by state
    always_comb begin
        fsm_busy         = 1'b0;
        memory_req       = 1'b0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        word_enable      = '0;
        data_out         = '0;
        fill_way         = way;
        memory_address   = base | (ADDR_W'(req_idx) << 1);
        if (state == FILL) begin
            fsm_busy   = 1'b1;
            memory_req = req_pending;
            if (memory_data_valid) begin
                write_data_array = 1'b1;
                word_enable      = WORDS'(1) << wr_idx;
                data_out         = memory_data;
                write_tag_array  = last_word;
            end
        end
    end

endmodule
